mem_arbiter: RTL
================

# mem_arbiter

Two-port to one-port memory arbiter that lets the instruction fetch unit (IFU) and the load/store unit (LSU) share one memory bus. It sits between the core's fetch/LSU paths and the single memory port. It replaces the combinational instruction and data accesses with valid/ready handshakes. It keeps at most one transaction outstanding and guards against a hung memory with a response timeout.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte mask width is DATA_W/8
- TIMEOUT, 255, maximum WAIT cycles before an error response; must be ≥1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- ifu_req_valid  in  1  fetch request
- ifu_req_ready  out  1  fetch request accepted this cycle
- ifu_addr  in  ADDR_W  fetch address
- ifu_resp_valid  out  1  fetch data valid (one-cycle pulse)
- ifu_rdata  out  DATA_W  fetch data
- ifu_resp_err  out  1  fetch timed out
- lsu_req_valid  in  1  load/store request
- lsu_req_ready  out  1  load/store request accepted this cycle
- lsu_addr  in  ADDR_W  data address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  DATA_W  store data
- lsu_wmask  in  DATA_W/8  store byte enables
- lsu_resp_valid  out  1  load data or store acknowledge (one-cycle pulse)
- lsu_rdata  out  DATA_W  load data
- lsu_resp_err  out  1  access timed out
- mem_req_valid  out  1  downstream request
- mem_req_ready  in  1  downstream accepts the request
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  request payload; widths as on the LSU side
- mem_resp_valid  in  1  downstream response
- mem_rdata  in  DATA_W  downstream read data

## Operation
- FSM states: IDLE, ISSUE, WAIT. The owner register holds NONE, IFU or LSU.
- IDLE
  - If any req_valid is high, the winner's req_ready is driven high combinationally in the same cycle.
  - The winner's payload is latched into the request registers and owner is set to the winner. Next state is ISSUE.
  - The loser's req_ready stays low. The loser must hold its request stable.
  - IFU requests latch mem_wen=0, wdata=0 and wmask=0.
- ISSUE
  - mem_req_valid=1 and the payload is driven from registers.
  - On mem_req_ready, go to WAIT and clear the timeout counter. Otherwise stay in ISSUE; the payload stays stable.
- WAIT
  - On mem_resp_valid, pulse the owner's resp_valid for that cycle. The owner's rdata passes through mem_rdata combinationally and resp_err=0. Go to IDLE.
  - If the counter reaches TIMEOUT with no response, pulse the owner's resp_valid with resp_err=1 and rdata=0. Go to IDLE.
- Both req_ready signals are low outside IDLE. A new request can therefore be accepted no earlier than the cycle after a response.
- mem_resp_valid in IDLE or ISSUE is ignored. No response is forwarded.
- A store receives a response exactly like a load. lsu_rdata carries mem_rdata, which the LSU ignores.
- Default arbitration is fixed priority: LSU wins simultaneous requests.

## Timing
- Reset values:
  - state=IDLE, owner=NONE
  - all *_ready, *_resp_valid and *_resp_err = 0
  - mem_req_valid=0
  - mem_addr, mem_wen, mem_wdata and mem_wmask = 0
  - timeout counter = 0
- Minimum transaction (memory ready immediately, response one cycle after acceptance):
  - cycle 0: req accepted
  - cycle 1: ISSUE handshake
  - cycle 2: resp_valid
  - cycle 3: next req can be accepted
- Timeout counter width is clog2(TIMEOUT+1). It saturates at TIMEOUT and never wraps.
- Reset asserted mid-transaction: immediate return to the reset state. The transaction is dropped with no response. A late mem_resp_valid after reset release is ignored because state is IDLE.
- Outputs are not glitch-protected. All handshakes are sampled on rising clk only.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - A last-grant bit records the previous winner. On simultaneous requests, the other requester wins.
  - With a single requester, that requester wins.
  - The last-grant bit resets to IFU, so LSU wins the first tie.
- MEM_ARB_RR_EN undefined: fixed LSU priority, and no last-grant register exists.

## Structure
- Package mem_arbiter_pkg holds:
  - the state enum (IDLE/ISSUE/WAIT)
  - the owner enum (NONE/IFU/LSU)
  - the default ADDR_W/DATA_W/TIMEOUT constants
- One sub-module, mem_arb_pick, is combinational. It takes the two valids and the last-grant bit, and outputs the one-hot grant. It contains the MEM_ARB_RR_EN switch.
- The top contains the FSM, request registers, timeout counter and response demux.

## Test plan
- Single IFU read:
  - Stimulus: ifu_addr=0x80000000, memory ready immediately, response next cycle with 0x00000413.
  - Expected: ifu_resp_valid exactly at cycle 2 with rdata=0x00000413, and lsu_resp_valid never asserted.
- Simultaneous requests, IFU 0x80000004 and LSU store 0x80001000 with wdata 0xDEADBEEF and wmask 0xF:
  - Fixed-priority build: LSU is served first and IFU second.
  - MEM_ARB_RR_EN build: repeat the tie twice and check the order LSU, IFU, LSU, IFU.
- mem_req_ready held low for 5 cycles in ISSUE:
  - mem_req_valid and payload stay stable for the entire stall.
  - Both req_ready signals stay low for the entire stall.
- No memory response, TIMEOUT=8:
  - Expected: a resp_valid pulse with resp_err=1 and rdata=0 on the 8th WAIT cycle.
  - Expected: FSM back in IDLE.
- Reset pulled low during WAIT, then mem_resp_valid=1 the cycle after release:
  - Expected: no resp_valid on either side.
  - Expected: all outputs at reset values.
- mem_resp_valid asserted in ISSUE before the handshake:
  - Expected: it is ignored, and only the WAIT-state response is forwarded.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM/owner encodings and default sizes for the IFU/LSU memory arbiter.
package mem_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic [1:0] {NONE, IFU, LSU} owner_t;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 255;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: one-hot grant between IFU and LSU; MEM_ARB_RR_EN selects round-robin, else fixed LSU priority.
module mem_arb_pick (
    input  logic ifu_valid,
    input  logic lsu_valid,
    input  logic last_lsu,
    output logic gnt_ifu,
    output logic gnt_lsu
);
`ifdef MEM_ARB_RR_EN
    assign gnt_lsu = lsu_valid && (!ifu_valid || !last_lsu);
`else
    logic unused_last;
    assign unused_last = last_lsu;
    assign gnt_lsu = lsu_valid;
`endif
    assign gnt_ifu = ifu_valid && !gnt_lsu;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between IFU and LSU with one outstanding transaction and a response timeout.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed LSU priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_resp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int CW = $clog2(TIMEOUT + 1);
    state_t state, state_d;
    owner_t owner, owner_d;
    logic [CW-1:0] cnt;
    logic gnt_ifu, gnt_lsu, last_lsu, accept, timed_out, done, err;

    mem_arb_pick u_pick (
        .ifu_valid(ifu_req_valid),
        .lsu_valid(lsu_req_valid),
        .last_lsu (last_lsu),
        .gnt_ifu  (gnt_ifu),
        .gnt_lsu  (gnt_lsu)
    );

    assign accept        = (state == IDLE) && (gnt_ifu || gnt_lsu);
    assign ifu_req_ready = (state == IDLE) && gnt_ifu;
    assign lsu_req_ready = (state == IDLE) && gnt_lsu;
    assign mem_req_valid = (state == ISSUE);
    // Counter holds elapsed WAIT cycles, so the TIMEOUT-th WAIT cycle is the last one.
    assign timed_out     = cnt >= CW'(TIMEOUT - 1);
    assign done          = (state == WAIT) && (mem_resp_valid || timed_out);
    assign err           = !mem_resp_valid;

    assign ifu_resp_valid = done && (owner == IFU);
    assign lsu_resp_valid = done && (owner == LSU);
    assign ifu_resp_err   = ifu_resp_valid && err;
    assign lsu_resp_err   = lsu_resp_valid && err;
    assign ifu_rdata      = (ifu_resp_valid && !err) ? mem_rdata : '0;
    assign lsu_rdata      = (lsu_resp_valid && !err) ? mem_rdata : '0;

    always_comb begin
        state_d = state;
        owner_d = owner;
        case (state)
            IDLE:  if (accept) begin
                state_d = ISSUE;
                owner_d = gnt_lsu ? LSU : IFU;
            end
            ISSUE: if (mem_req_ready) state_d = WAIT;
            WAIT:  if (done) begin
                state_d = IDLE;
                owner_d = NONE;
            end
            default: begin
                state_d = IDLE;
                owner_d = NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= NONE;
            mem_addr  <= '0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            cnt       <= '0;
        end else begin
            state <= state_d;
            owner <= owner_d;
            if (accept) begin
                mem_addr  <= gnt_lsu ? lsu_addr : ifu_addr;
                mem_wen   <= gnt_lsu && lsu_wen;
                mem_wdata <= gnt_lsu ? lsu_wdata : '0;
                mem_wmask <= gnt_lsu ? lsu_wmask : '0;
            end
            if (state == ISSUE) cnt <= '0;
            else if (state == WAIT && cnt != CW'(TIMEOUT)) cnt <= cnt + 1'b1;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last_lsu <= 1'b0;
        else if (accept) last_lsu <= gnt_lsu;
    end
`else
    assign last_lsu = 1'b0;
`endif
endmodule
